hazard_ctrl: RTL and testbench

- Pipeline hazard and multiply/divide sequencing controller for the 5-stage MIPS core.
- Watches the ID-stage instruction and the ID/EX register contents, then drives PC/IF-ID enables, IF/ID flush and the ID/EX control bubble.
- Owns a small FSM that sequences the multi-cycle MDU and pulses the HI/LO write.
- The ID/EX register has no enable: a stall is a bubble, meaning zeroed control fields muxed in by `idex_bubble`.

---
 rtl/cpu_ctrl_pkg.sv | 6 +
 rtl/mdu_sequencer.sv | 39 +++
 rtl/hazard_ctrl.sv | 61 ++++++
 tb/tb_hazard_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared MDU state encoding and constants for the pipeline control logic.
package cpu_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} mdu_state_t;
   localparam int MDU_CNT_W = 6;
   localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: counts the multi-cycle MDU operation and pulses the HI/LO write at the end.
module mdu_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_start,
   input  logic i_div,
   output logic o_op,
   output logic o_busy,
   output logic o_hilo_we
);
   localparam logic [MDU_CNT_W-1:0] MULT_LD = MDU_CNT_W'(MULT_CYCLES - 1);
   localparam logic [MDU_CNT_W-1:0] DIV_LD  = MDU_CNT_W'(DIV_CYCLES - 1);
   mdu_state_t r_state, w_next;
   logic [MDU_CNT_W-1:0] r_cnt;
   logic r_op, w_load, w_run;
   assign w_load = r_state == IDLE && i_start;
   assign w_run  = r_state == MULT || r_state == DIV;
   assign w_next = w_load ? (i_div ? DIV : MULT)
                 : r_state == DONE ? IDLE
                 : w_run && r_cnt == '0 ? DONE : r_state;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_op    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_load ? (i_div ? DIV_LD : MULT_LD) : w_run && r_cnt != '0 ? r_cnt - 1'b1 : r_cnt;
         r_op    <= w_load ? i_div : r_op;
      end
   assign o_op      = r_op;
   assign o_busy    = r_state != IDLE;
   assign o_hilo_we = r_state == DONE;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / MDU stall and branch flush control for the 5-stage MIPS core.
// Define MDU_INTERLOCK_EN to hold mfhi/mflo in ID while the MDU is busy.
module hazard_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rs,
   input  logic       id_uses_rt,
   input  logic       id_mfhi,
   input  logic       id_mflo,
   input  logic       id_mdu_start,
   input  logic       id_mdu_div,
   input  logic       ex_memread,
   input  logic [4:0] ex_rt,
   input  logic       ex_branch_taken,
   output logic       pc_en,
   output logic       ifid_en,
   output logic       ifid_flush,
   output logic       idex_bubble,
   output logic       mdu_start,
   output logic       mdu_op,
   output logic       mdu_busy,
   output logic       hilo_we
);
`ifdef MDU_INTERLOCK_EN
   localparam logic HILO_IL = 1'b1;
`else
   localparam logic HILO_IL = 1'b0;
`endif
   logic w_load_use, w_mdu_struct, w_hilo_dep, w_stall, w_flush;
   assign w_load_use   = ex_memread && ex_rt != REG_ZERO &&
                         ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
   assign w_mdu_struct = id_mdu_start && mdu_busy;
   assign w_hilo_dep   = HILO_IL && (id_mfhi || id_mflo) && mdu_busy;
   assign w_stall      = w_load_use || w_mdu_struct || w_hilo_dep;
   assign w_flush      = ex_branch_taken;
   // While in reset the front end is frozen and IF/ID and ID/EX are forced to nops.
   assign pc_en       = rst_n && (w_flush || !w_stall);
   assign ifid_en     = rst_n && (w_flush || !w_stall);
   assign ifid_flush  = !rst_n || w_flush;
   assign idex_bubble = !rst_n || w_flush || w_stall;
   assign mdu_start   = rst_n && id_mdu_start && !w_stall && !w_flush;
   mdu_sequencer #(
      .MULT_CYCLES(MULT_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_mdu (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_start  (mdu_start),
      .i_div    (id_mdu_div),
      .o_op     (mdu_op),
      .o_busy   (mdu_busy),
      .o_hilo_we(hilo_we)
   );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scenario tasks with a per-cycle expected-output scoreboard for hazard_ctrl.
module tb_hazard_ctrl;
   localparam logic [7:0] NORM = 8'hC0, STALL = 8'h10, FLUSH = 8'hF0, RSTV = 8'h30;
   localparam logic [7:0] ST = 8'h08, BUSY = 8'h04, OP = 8'h02, WE = 8'h01;
`ifdef MDU_INTERLOCK_EN
   localparam logic [7:0] HOLD = STALL;
`else
   localparam logic [7:0] HOLD = NORM;
`endif
   logic clk = 1'b0, rst_n = 1'b0;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic id_uses_rs, id_uses_rt, id_mfhi, id_mflo, id_mdu_start, id_mdu_div, ex_memread, ex_branch_taken;
   logic pc_en, ifid_en, ifid_flush, idex_bubble, mdu_start, mdu_op, mdu_busy, hilo_we;
   logic [7:0] act;
   logic [7:0] sb[$];
   int n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   assign act = {pc_en, ifid_en, ifid_flush, idex_bubble, mdu_start, mdu_busy, mdu_op, hilo_we};

   hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
      .id_uses_rt(id_uses_rt), .id_mfhi(id_mfhi), .id_mflo(id_mflo), .id_mdu_start(id_mdu_start),
      .id_mdu_div(id_mdu_div), .ex_memread(ex_memread), .ex_rt(ex_rt),
      .ex_branch_taken(ex_branch_taken), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .mdu_start(mdu_start), .mdu_op(mdu_op), .mdu_busy(mdu_busy),
      .hilo_we(hilo_we)
   );

   task automatic idle_in();
      id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rs = 0; id_uses_rt = 0; id_mfhi = 0; id_mflo = 0;
      id_mdu_start = 0; id_mdu_div = 0; ex_memread = 0; ex_branch_taken = 0;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [7:0] e;
      idle_in();
      id_mdu_start = 1; ex_memread = 1; ex_rt = 3; id_rs = 3; id_uses_rs = 1;
      sb.push_back(RSTV);
      @(negedge clk);
      e = sb.pop_front(); n_chk++;
      if (act !== e) begin n_fail++; $display("FAIL reset_hold: got %b expected %b", act, e); end
      next();
      idle_in(); rst_n = 1;
      sb.push_back(NORM);
      @(negedge clk);
      e = sb.pop_front(); n_chk++;
      if (act !== e) begin n_fail++; $display("FAIL reset_release: got %b expected %b", act, e); end
      next();
   endtask

   task automatic test_load_use();
      logic [7:0] e;
      bit mr[9]        = '{1, 0, 1, 1, 1, 1, 1, 1, 0};
      int ert[9]       = '{5, 5, 9, 9, 0, 5, 5, 5, 0};
      int rs[9]        = '{5, 5, 1, 1, 0, 6, 5, 5, 0};
      int rt[9]        = '{0, 0, 9, 9, 0, 7, 0, 0, 0};
      bit urs[9]       = '{1, 1, 1, 1, 1, 1, 0, 1, 0};
      bit urt[9]       = '{0, 0, 1, 0, 1, 1, 0, 0, 0};
      bit ms[9]        = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
      logic [7:0] x[9] = '{STALL, NORM, STALL, NORM, NORM, NORM, NORM, STALL, NORM};
      for (int i = 0; i < 9; i++) begin
         idle_in();
         ex_memread = mr[i]; ex_rt = 5'(ert[i]); id_rs = 5'(rs[i]); id_rt = 5'(rt[i]);
         id_uses_rs = urs[i]; id_uses_rt = urt[i]; id_mdu_start = ms[i];
         sb.push_back(x[i]);
         @(negedge clk);
         e = sb.pop_front(); n_chk++;
         if (act !== e) begin n_fail++; $display("FAIL load_use[%0d]: got %b expected %b", i, act, e); end
         next();
      end
   endtask

   task automatic test_mult_hilo();
      logic [7:0] e;
      idle_in(); id_mdu_start = 1;
      sb.push_back(NORM | ST);
      @(negedge clk);
      e = sb.pop_front(); n_chk++;
      if (act !== e) begin n_fail++; $display("FAIL mult_start: got %b expected %b", act, e); end
      next();
      idle_in(); id_mfhi = 1;
      for (int k = 1; k <= 6; k++) begin
         sb.push_back(k <= 5 ? (HOLD | BUSY | (k == 5 ? WE : 8'h00)) : NORM);
         @(negedge clk);
         e = sb.pop_front(); n_chk++;
         if (act !== e) begin n_fail++; $display("FAIL mult_mfhi[T+%0d]: got %b expected %b", k, act, e); end
         next();
      end
      idle_in();
   endtask

   task automatic test_back_to_back();
      logic [7:0] e;
      idle_in(); id_mdu_start = 1; id_mdu_div = 1;
      sb.push_back(NORM | ST);
      @(negedge clk);
      e = sb.pop_front(); n_chk++;
      if (act !== e) begin n_fail++; $display("FAIL div_start: got %b expected %b", act, e); end
      next();
      id_mdu_div = 0;
      for (int k = 1; k <= 34; k++) begin
         sb.push_back(k <= 33 ? (STALL | BUSY | OP | (k == 33 ? WE : 8'h00)) : (NORM | ST | OP));
         @(negedge clk);
         e = sb.pop_front(); n_chk++;
         if (act !== e) begin n_fail++; $display("FAIL div_struct[T+%0d]: got %b expected %b", k, act, e); end
         next();
      end
      idle_in();
      for (int k = 1; k <= 6; k++) begin
         sb.push_back(k <= 5 ? (NORM | BUSY | (k == 5 ? WE : 8'h00)) : NORM);
         @(negedge clk);
         e = sb.pop_front(); n_chk++;
         if (act !== e) begin n_fail++; $display("FAIL mult_after_div[%0d]: got %b expected %b", k, act, e); end
         next();
      end
   endtask

   task automatic test_flush();
      logic [7:0] e;
      idle_in();
      ex_memread = 1; ex_rt = 7; id_rs = 7; id_uses_rs = 1; id_mdu_start = 1; ex_branch_taken = 1;
      sb.push_back(FLUSH);
      @(negedge clk);
      e = sb.pop_front(); n_chk++;
      if (act !== e) begin n_fail++; $display("FAIL flush_priority: got %b expected %b", act, e); end
      next();
      idle_in();
      sb.push_back(NORM);
      @(negedge clk);
      e = sb.pop_front(); n_chk++;
      if (act !== e) begin n_fail++; $display("FAIL flush_no_start: got %b expected %b", act, e); end
      next();
      id_mdu_start = 1;
      sb.push_back(NORM | ST);
      @(negedge clk);
      e = sb.pop_front(); n_chk++;
      if (act !== e) begin n_fail++; $display("FAIL flush_mult_start: got %b expected %b", act, e); end
      next();
      for (int k = 1; k <= 6; k++) begin
         idle_in();
         if (k == 1) begin ex_branch_taken = 1; id_mdu_start = 1; end
         sb.push_back(k == 1 ? (FLUSH | BUSY) : k <= 5 ? (NORM | BUSY | (k == 5 ? WE : 8'h00)) : NORM);
         @(negedge clk);
         e = sb.pop_front(); n_chk++;
         if (act !== e) begin n_fail++; $display("FAIL flush_busy[T+%0d]: got %b expected %b", k, act, e); end
         next();
      end
   endtask

   task automatic test_reset_mid_div();
      logic [7:0] e;
      idle_in(); id_mdu_start = 1; id_mdu_div = 1;
      sb.push_back(NORM | ST);
      @(negedge clk);
      e = sb.pop_front(); n_chk++;
      if (act !== e) begin n_fail++; $display("FAIL rdiv_start: got %b expected %b", act, e); end
      next();
      idle_in();
      for (int k = 1; k <= 12; k++) begin
         if (k == 10) rst_n = 0;
         if (k == 12) rst_n = 1;
         sb.push_back(k < 10 ? (NORM | BUSY | OP) : k < 12 ? RSTV : NORM);
         @(negedge clk);
         e = sb.pop_front(); n_chk++;
         if (act !== e) begin n_fail++; $display("FAIL reset_mid[T+%0d]: got %b expected %b", k, act, e); end
         next();
      end
      for (int k = 0; k < 40; k++) begin
         sb.push_back(NORM);
         @(negedge clk);
         e = sb.pop_front(); n_chk++;
         if (act !== e) begin n_fail++; $display("FAIL post_reset_idle[%0d]: got %b expected %b", k, act, e); end
         next();
      end
   endtask

   initial begin
      idle_in();
      rst_n = 0;
      next();
      test_reset();
      test_load_use();
      test_mult_hilo();
      test_back_to_back();
      test_flush();
      test_reset_mid_div();
      if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d expected 0", sb.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
